// File: rtl/serial_addsub.sv
// Digit-serial WIDTH-bit adder/subtractor: DIGIT bits per clock, LSB first,
// with a registered carry between digits and a one-cycle done pulse.
module serial_addsub #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             Ovf
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_s;
    logic             r_carry;
    logic             r_cout;
    logic             r_ovf;
    logic [CW-1:0]    r_cnt;

    logic             w_accept;
    logic             w_last;
    logic [DIGIT:0]   w_sum;
    logic [DIGIT-1:0] w_d;
    logic             w_c;
    logic             w_c_msb_in;
    logic [WIDTH-1:0] w_a_shr;
    logic [WIDTH-1:0] w_b_shr;
    logic [WIDTH-1:0] w_s_ins;

    assign w_accept   = start && (r_state != ST_RUN);
    assign w_last     = (r_cnt == CW'(N - 1));
    assign w_sum      = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]}
                      + {{DIGIT{1'b0}}, r_carry};
    assign w_d        = w_sum[DIGIT-1:0];
    assign w_c        = w_sum[DIGIT];
    // Carry into the top bit of the digit, recovered from that bit's sum.
    assign w_c_msb_in = r_a[DIGIT-1] ^ r_b[DIGIT-1] ^ w_d[DIGIT-1];

    generate
        if (N == 1) begin : g_single
            assign w_a_shr = '0;
            assign w_b_shr = '0;
            assign w_s_ins = w_d;
        end else begin : g_multi
            assign w_a_shr = {{DIGIT{1'b0}}, r_a[WIDTH-1:DIGIT]};
            assign w_b_shr = {{DIGIT{1'b0}}, r_b[WIDTH-1:DIGIT]};
            // Digits enter at the top; after N shifts digit 0 sits at bit 0.
            assign w_s_ins = {w_d, r_s[WIDTH-1:DIGIT]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: w_state_next = start ? ST_RUN : ST_IDLE;
            ST_RUN:           w_state_next = w_last ? ST_DONE : ST_RUN;
            default:          w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == ST_RUN);
        done = (r_state == ST_DONE);
        S    = r_s;
        Cout = r_cout;
        Ovf  = r_ovf;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_s     <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_a     <= X;
            r_b     <= sub ? ~Y : Y;
            r_carry <= sub ? 1'b1 : Cin;
            r_s     <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
        end else if (r_state == ST_RUN) begin
            r_a     <= w_a_shr;
            r_b     <= w_b_shr;
            r_s     <= w_s_ins;
            r_carry <= w_c;
            r_cnt   <= r_cnt + 1'b1;
            if (w_last) begin
                r_cout <= w_c;
                r_ovf  <= w_c ^ w_c_msb_in;
            end
        end
    end

endmodule
